led_ws2812_tx: RTL and testbench
================================

Name: led_ws2812_tx

Overview:
- Downstream consumer of the zone-to-FIFO sequencer in the LED PHY path.
- On a send_start pulse, reads LED_NUM 12-bit RGB444 words from the synchronous LED FIFO.
- Expands each word to 24-bit GRB888 and drives the one-wire WS2812 data line with NRZ bit timing.
- Closes each frame with a latch (reset) low period.

Parameters:
- LED_NUM, 47, pixels per frame (FIFO words consumed per send_start).
- T_BIT, 63, clocks per data bit (1.25 us at 50 MHz).
- T0H, 20, high clocks for a '0' bit.
- T1H, 40, high clocks for a '1' bit.
- T_LATCH, 15000, low clocks after the last bit (300 us).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- send_start  in  1  single-cycle frame trigger.
- fifo_empty  in  1  LED FIFO empty flag.
- fifo_rdata  in  12  {R[3:0],G[3:0],B[3:0]}, valid the cycle after fifo_re.
- fifo_re  out  1  FIFO read strobe, one cycle per pixel.
- dout  out  1  WS2812 serial data line.
- busy  out  1  high from the cycle after an accepted send_start until DONE.
- done  out  1  one-cycle pulse at end of latch.
- underrun  out  1  sticky: FIFO was empty when a pixel was fetched. Cleared by the next accepted send_start.

Behaviour:
- Reset is synchronous: on rst=1 at a clock edge, every output goes 0 (dout=0, fifo_re=0, busy=0, done=0, underrun=0), state goes to IDLE, and all counters clear. This applies mid-frame too: dout drops low on the same edge.
- States: IDLE, FETCH, LOAD, BIT_HI, BIT_LO, NEXT, LATCH, DONE.
- IDLE:
  - send_start=1 → FETCH; pix_cnt=0; underrun cleared.
  - send_start is ignored in all other states; no queueing.
- FETCH (1 cycle):
  - If fifo_empty=0, assert fifo_re=1.
  - If empty, fifo_re stays 0, pixel is substituted with 12'h000, and underrun is set.
  - Always → LOAD.
- LOAD (1 cycle):
  - Capture the pixel into a 24-bit shift register as {G8,R8,B8}, MSB first.
  - Expansion: c8 = {c4,c4} (c4×17), so 4'hF→8'hFF and 4'h1→8'h11.
  - bit_cnt=23 → BIT_HI.
- BIT_HI:
  - dout=1; tick counter runs from 0.
  - Leave after TH clocks, where TH = T1H if sr[23] else T0H → BIT_LO.
- BIT_LO:
  - dout=0 for T_BIT−TH clocks.
  - If bit_cnt≠0: shift left, decrement bit_cnt → BIT_HI.
  - Else → NEXT.
- Bit period is exactly T_BIT clocks (HI+LO) with no gaps between bits of one pixel.
- Pixel-boundary gap: NEXT+FETCH+LOAD add 3 low clocks (60 ns at 50 MHz), which is within the WS2812 TxL tolerance.
- NEXT (1 cycle):
  - pix_cnt==LED_NUM−1 → LATCH.
  - Else pix_cnt++ → FETCH.
- LATCH: dout=0 for T_LATCH clocks → DONE.
- DONE: done=1 for 1 cycle → IDLE; busy drops the same cycle.
- Counter widths: tick_cnt is $clog2(max(T_BIT,T_LATCH)+1) bits; pix_cnt is $clog2(LED_NUM+1) bits; neither wraps within a frame.
- dout is a registered output, glitch-free.
- Exactly LED_NUM fifo_re pulses per frame when the FIFO is never empty; fewer by the number of empty fetches otherwise.

Optional Feature:
- Macro: LED_WS2812_GAMMA_EN.
- Defined: 4→8-bit expansion uses the gamma-2.2 LUT instead of replication. Indices 0..15 map to 0,1,3,7,14,23,34,48,64,83,105,129,156,186,219,255. Timing is unchanged (LUT is combinational in the LOAD path).
- Undefined: replication {c4,c4}.

Test Plan:
- Frame timing: LED_NUM=2, FIFO preloaded 12'hF00, 12'h00F, send_start pulse. Required:
  - Exactly 2 fifo_re pulses.
  - Bit stream pixel0 = 24'h00FF00 (G=00,R=FF,B=00) and pixel1 = 24'h0000FF, MSB first.
  - '1' bits high 40 clocks, '0' bits high 20 clocks, each bit 63 clocks.
  - Then 15000 low clocks, then done=1 for one cycle; busy 1→0.
- Expansion: pixel 12'h5A3 → 24'hAA_55_33 (G,R,B). With LED_WS2812_GAMMA_EN: 24'h69_17_07.
- Underrun: LED_NUM=3, FIFO holds 1 word 12'hFFF. Required:
  - fifo_re pulses once only.
  - Pixels 2 and 3 are all-'0' bits (20 high / 43 low).
  - underrun=1 after the 2nd fetch and stays 1 through done.
  - Next send_start clears it.
- Start while busy: second send_start mid-pixel 0 → no effect. Total fifo_re count equals LED_NUM; a single done.
- Reset mid-frame: rst=1 during BIT_HI of pixel 1 → same edge dout=0, busy=0, fifo_re=0. After release, IDLE; a new send_start starts a clean frame at pixel 0.
- Back-to-back: send_start asserted the cycle done=1 → ignored. send_start one cycle after done → accepted; next frame begins with FETCH.

Source files
------------

// File: rtl/led_ws2812_tx.sv
// led_ws2812_tx: serialises LED_NUM RGB444 pixels from a synchronous FIFO
// onto a WS2812 one-wire data line (GRB888, MSB first, NRZ timing), then
// holds the line low for the latch period.
// Build option: define LED_WS2812_GAMMA_EN to expand 4-bit channels through
// a gamma-2.2 table instead of nibble replication.
//
// FIFO handshake: fifo_re is asserted for one cycle in FETCH only when
// fifo_empty is low; the word is taken from fifo_rdata on the following
// cycle (LOAD). An empty FIFO at FETCH substitutes a black pixel and sets
// the sticky underrun flag.
module led_ws2812_tx #(
   parameter int LED_NUM = 47,
   parameter int T_BIT   = 63,
   parameter int T0H     = 20,
   parameter int T1H     = 40,
   parameter int T_LATCH = 15000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        send_start,
   input  logic        fifo_empty,
   input  logic [11:0] fifo_rdata,
   output logic        fifo_re,
   output logic        dout,
   output logic        busy,
   output logic        done,
   output logic        underrun,
   output logic [2:0]  state_dbg
);

   localparam int TICK_MAX = (T_BIT > T_LATCH) ? T_BIT : T_LATCH;
   localparam int TW       = $clog2(TICK_MAX + 1);
   localparam int PW       = $clog2(LED_NUM + 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_LOAD   = 3'd2,
      S_BIT_HI = 3'd3,
      S_BIT_LO = 3'd4,
      S_NEXT   = 3'd5,
      S_LATCH  = 3'd6,
      S_DONE   = 3'd7
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic            r_dout;
   logic            r_underrun;
   logic            r_sub;
   logic [23:0]     r_sr;
   logic [4:0]      r_bit_cnt;
   logic [TW-1:0]   r_tick;
   logic [PW-1:0]   r_pix_cnt;
   logic [TW-1:0]   w_th;
   logic            w_hi_end;
   logic            w_lo_end;
   logic            w_latch_end;
   logic [11:0]     w_pix;
   logic [23:0]     w_grb;

   // 4-bit to 8-bit channel expansion
   function automatic logic [7:0] expand(input logic [3:0] c);
`ifdef LED_WS2812_GAMMA_EN
      logic [7:0] g;
      case (c)
         4'd0:    g = 8'd0;
         4'd1:    g = 8'd1;
         4'd2:    g = 8'd3;
         4'd3:    g = 8'd7;
         4'd4:    g = 8'd14;
         4'd5:    g = 8'd23;
         4'd6:    g = 8'd34;
         4'd7:    g = 8'd48;
         4'd8:    g = 8'd64;
         4'd9:    g = 8'd83;
         4'd10:   g = 8'd105;
         4'd11:   g = 8'd129;
         4'd12:   g = 8'd156;
         4'd13:   g = 8'd186;
         4'd14:   g = 8'd219;
         default: g = 8'd255;
      endcase
      return g;
`else
      return {c, c};
`endif
   endfunction

   // High time depends on the bit currently at the head of the shift register
   assign w_th        = r_sr[23] ? TW'(T1H) : TW'(T0H);
   assign w_hi_end    = (r_tick == w_th - TW'(1));
   assign w_lo_end    = (r_tick == TW'(T_BIT) - w_th - TW'(1));
   assign w_latch_end = (r_tick == TW'(T_LATCH - 1));

   // Pixel word seen in LOAD: black if the fetch found the FIFO empty
   assign w_pix = r_sub ? 12'h000 : fifo_rdata;
   assign w_grb = {expand(w_pix[7:4]), expand(w_pix[11:8]), expand(w_pix[3:0])};

   // Next-state decode
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:   if (send_start) w_state_nxt = S_FETCH;
         S_FETCH:  w_state_nxt = S_LOAD;
         S_LOAD:   w_state_nxt = S_BIT_HI;
         S_BIT_HI: if (w_hi_end) w_state_nxt = S_BIT_LO;
         S_BIT_LO: if (w_lo_end) w_state_nxt = (r_bit_cnt != 5'd0) ? S_BIT_HI : S_NEXT;
         S_NEXT:   w_state_nxt = (r_pix_cnt == PW'(LED_NUM - 1)) ? S_LATCH : S_FETCH;
         S_LATCH:  if (w_latch_end) w_state_nxt = S_DONE;
         S_DONE:   w_state_nxt = S_IDLE;
         default:  w_state_nxt = S_IDLE;
      endcase
   end

   // State register, registered data line, counters and datapath
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_dout     <= 1'b0;
         r_underrun <= 1'b0;
         r_sub      <= 1'b0;
         r_sr       <= '0;
         r_bit_cnt  <= '0;
         r_tick     <= '0;
         r_pix_cnt  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_dout  <= (w_state_nxt == S_BIT_HI);
         case (r_state)
            S_IDLE: begin
               r_tick <= '0;
               if (send_start) begin
                  r_pix_cnt  <= '0;
                  r_underrun <= 1'b0;
               end
            end
            S_FETCH: begin
               r_sub <= fifo_empty;
               if (fifo_empty) r_underrun <= 1'b1;
            end
            S_LOAD: begin
               r_sr      <= w_grb;
               r_bit_cnt <= 5'd23;
               r_tick    <= '0;
            end
            S_BIT_HI: r_tick <= w_hi_end ? '0 : r_tick + TW'(1);
            S_BIT_LO: begin
               if (w_lo_end) begin
                  r_tick <= '0;
                  if (r_bit_cnt != 5'd0) begin
                     r_sr      <= {r_sr[22:0], 1'b0};
                     r_bit_cnt <= r_bit_cnt - 5'd1;
                  end
               end else begin
                  r_tick <= r_tick + TW'(1);
               end
            end
            S_NEXT: begin
               r_tick <= '0;
               if (r_pix_cnt != PW'(LED_NUM - 1)) r_pix_cnt <= r_pix_cnt + PW'(1);
            end
            S_LATCH: r_tick <= r_tick + TW'(1);
            default: r_tick <= '0;
         endcase
      end
   end

   assign fifo_re   = (r_state == S_FETCH) && !fifo_empty;
   assign busy      = (r_state != S_IDLE) && (r_state != S_DONE);
   assign done      = (r_state == S_DONE);
   assign dout      = r_dout;
   assign underrun  = r_underrun;
   assign state_dbg = r_state;

endmodule

// File: tb/tb_led_ws2812_tx.sv
// Bench for led_ws2812_tx with a two-pixel frame and default bit timing.
module tb_led_ws2812_tx;

   logic        clk = 1'b0;
   logic        rst;
   logic        send_start;
   logic        fifo_empty;
   logic [11:0] fifo_rdata = 12'h000;
   logic        fifo_re;
   logic        dout;
   logic        busy;
   logic        done;
   logic        underrun;
   logic [2:0]  state_dbg;

`ifdef LED_WS2812_GAMMA_EN
   localparam logic [23:0] EXP_5A3  = 24'h691707;
   localparam logic [23:0] EXP_1E7  = 24'hDB0130;
   localparam logic [23:0] EXP_800  = 24'h004000;
   localparam int          EXP_BND4 = 46;
`else
   localparam logic [23:0] EXP_5A3  = 24'hAA5533;
   localparam logic [23:0] EXP_1E7  = 24'hEE1177;
   localparam logic [23:0] EXP_800  = 24'h008800;
   localparam int          EXP_BND4 = 26;
`endif

   led_ws2812_tx #(.LED_NUM(2)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .send_start (send_start),
      .fifo_empty (fifo_empty),
      .fifo_rdata (fifo_rdata),
      .fifo_re    (fifo_re),
      .dout       (dout),
      .busy       (busy),
      .done       (done),
      .underrun   (underrun),
      .state_dbg  (state_dbg)
   );

   // clock
   always #5 clk = ~clk;

   // synchronous FIFO model: word appears the cycle after fifo_re
   logic [11:0] fifo_mem [0:15];
   int wr_ptr = 0;
   int rd_ptr = 0;
   assign fifo_empty = (rd_ptr == wr_ptr);
   always @(posedge clk) begin
      if (fifo_re) begin
         fifo_rdata <= fifo_mem[rd_ptr];
         rd_ptr     <= rd_ptr + 1;
      end
   end

   // line decoder: records high/low run lengths per bit and event counts
   int  hi_arr [0:511];
   int  lo_arr [0:511];
   int  nbits = 0, hi_run = 0, lo_run = 0, latch_lo = 0;
   int  re_cnt = 0, done_cnt = 0;
   bit  prev_dout = 1'b0;
   always @(negedge clk) begin
      if (fifo_re) re_cnt++;
      if (done) done_cnt++;
      if (dout) begin
         if (!prev_dout) begin
            if (nbits > 0) lo_arr[nbits-1] = lo_run;
            hi_run = 0;
         end
         hi_run++;
      end else begin
         if (prev_dout) begin
            hi_arr[nbits] = hi_run;
            nbits++;
            lo_run = 0;
         end
         lo_run++;
      end
      if (done) latch_lo = lo_run;
      prev_dout = dout;
   end

   // scoreboard
   int n_cmp = 0;
   int n_err = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic push(input logic [11:0] w);
      fifo_mem[wr_ptr] = w;
      wr_ptr = wr_ptr + 1;
   endtask

   function automatic logic [23:0] pix_word(input int b);
      logic [23:0] w;
      w = '0;
      for (int i = 0; i < 24; i++) w = {w[22:0], (hi_arr[b+i] == 40)};
      return w;
   endfunction

   task automatic wait_done(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (done) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   // single-cycle start pulse; returns at the first negedge after acceptance
   task automatic pulse_start;
      @(negedge clk);
      send_start = 1'b1;
      @(negedge clk);
      send_start = 1'b0;
   endtask

   // timing of a complete two-pixel frame starting at bit index b
   task automatic check_frame_bits(input string pfx, input int b, input int exp_bnd);
      int bad;
      bad = 0;
      for (int i = 0; i < 48; i++) begin
         if (hi_arr[b+i] != 20 && hi_arr[b+i] != 40) bad++;
         if ((i % 24) != 23 && hi_arr[b+i] + lo_arr[b+i] != 63) bad++;
      end
      check_val({pfx, "_bit_timing_bad"}, bad, 0);
      check_val({pfx, "_pixel_gap_low"}, lo_arr[b+23], exp_bnd);
   endtask

   int base, re0, d0;
   bit ok;

   initial begin
      rst = 1'b1;
      send_start = 1'b0;
      repeat (3) @(negedge clk);
      check_val("rst_dout", dout, 0);
      check_val("rst_busy", busy, 0);
      check_val("rst_done", done, 0);
      check_val("rst_fifo_re", fifo_re, 0);
      check_val("rst_underrun", underrun, 0);
      rst = 1'b0;

      // frame 1: F00, 00F, with an ignored second start mid-pixel 0
      push(12'hF00);
      push(12'h00F);
      base = nbits; re0 = re_cnt; d0 = done_cnt;
      pulse_start();
      check_val("f1_busy_after_start", busy, 1);
      check_val("f1_first_fetch_re", fifo_re, 1);
      repeat (500) @(negedge clk);
      send_start = 1'b1;
      @(negedge clk);
      send_start = 1'b0;
      wait_done(30000, ok);
      check_val("f1_done_seen", ok, 1);
      check_val("f1_busy_at_done", busy, 0);
      repeat (3) @(negedge clk);
      check_val("f1_done_low_after", done, 0);
      check_val("f1_re_pulses", re_cnt - re0, 2);
      check_val("f1_done_pulses", done_cnt - d0, 1);
      check_val("f1_bit_count", nbits - base, 48);
      check_val("f1_pix0", pix_word(base), 24'h00FF00);
      check_val("f1_pix1", pix_word(base + 24), 24'h0000FF);
      check_frame_bits("f1", base, 46);
      // last bit '1': 23 low + NEXT + 15000 latch + DONE
      check_val("f1_latch_low", latch_lo, 15025);
      check_val("f1_underrun", underrun, 0);

      // frame 2: only one word available -> underrun on pixel 1
      push(12'hFFF);
      base = nbits; re0 = re_cnt; d0 = done_cnt;
      pulse_start();
      ok = 1'b0;
      for (int i = 0; i < 5000; i++) begin
         @(negedge clk);
         if (nbits - base >= 25) begin
            ok = 1'b1;
            break;
         end
      end
      check_val("f2_pix1_started", ok, 1);
      check_val("f2_underrun_after_fetch2", underrun, 1);
      wait_done(30000, ok);
      check_val("f2_done_seen", ok, 1);
      check_val("f2_underrun_at_done", underrun, 1);
      // start during the done cycle must be ignored
      send_start = 1'b1;
      @(negedge clk);
      check_val("b2b_start_at_done_ignored", busy, 0);
      check_val("f2_re_pulses", re_cnt - re0, 1);
      check_val("f2_done_pulses", done_cnt - d0, 1);
      check_val("f2_pix0", pix_word(base), 24'hFFFFFF);
      check_val("f2_pix1", pix_word(base + 24), 24'h000000);
      check_frame_bits("f2", base, 26);
      check_val("f2_latch_low", latch_lo, 15045);

      // frame 3: start held one cycle after done is accepted
      push(12'h5A3);
      push(12'h1E7);
      base = nbits; re0 = re_cnt;
      @(negedge clk);
      send_start = 1'b0;
      check_val("b2b_busy", busy, 1);
      check_val("b2b_fetch_re", fifo_re, 1);
      check_val("b2b_underrun_cleared", underrun, 0);
      ok = 1'b0;
      for (int i = 0; i < 5000; i++) begin
         @(negedge clk);
         if (nbits - base >= 24 && dout) begin
            ok = 1'b1;
            break;
         end
      end
      check_val("f3_pix1_high_seen", ok, 1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check_val("midrst_dout", dout, 0);
      check_val("midrst_busy", busy, 0);
      check_val("midrst_fifo_re", fifo_re, 0);
      @(negedge clk);
      rst = 1'b0;
      check_val("f3_pix0_expand", pix_word(base), EXP_5A3);
      check_val("f3_re_pulses", re_cnt - re0, 2);
      @(negedge clk);
      check_val("midrst_state_idle", state_dbg, 0);

      // frame 4: clean frame after reset
      push(12'h1E7);
      push(12'h800);
      base = nbits; re0 = re_cnt; d0 = done_cnt;
      pulse_start();
      check_val("f4_first_fetch_re", fifo_re, 1);
      wait_done(30000, ok);
      check_val("f4_done_seen", ok, 1);
      repeat (3) @(negedge clk);
      check_val("f4_re_pulses", re_cnt - re0, 2);
      check_val("f4_done_pulses", done_cnt - d0, 1);
      check_val("f4_bit_count", nbits - base, 48);
      check_val("f4_pix0", pix_word(base), EXP_1E7);
      check_val("f4_pix1", pix_word(base + 24), EXP_800);
      check_frame_bits("f4", base, EXP_BND4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
